// File: rtl/sdram_write_if.sv
// Write-phase bus between the FIFO controller/arbiter and the SDRAM write engine.
// The master side requests a burst and supplies FIFO data; the slave side
// (sdram_write) returns the FIFO read strobe and drives the SDRAM command bus.
interface sdram_write_if;
  logic        init_end;
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [9:0]  wr_burst_len;
  logic [15:0] wr_data;
  logic        wr_ack;
  logic        wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_ba;
  logic [12:0] wr_sdram_addr;
  logic [15:0] wr_dq;
  logic        wr_dq_oe;

  modport master (
    output init_end, wr_en, wr_addr, wr_burst_len, wr_data,
    input  wr_ack, wr_end, wr_cmd, wr_ba, wr_sdram_addr, wr_dq, wr_dq_oe
  );

  modport slave (
    input  init_end, wr_en, wr_addr, wr_burst_len, wr_data,
    output wr_ack, wr_end, wr_cmd, wr_ba, wr_sdram_addr, wr_dq, wr_dq_oe
  );
endinterface

// File: rtl/sdram_write.sv
// SDRAM write engine: ACTIVE, one full-page WRITE burst fed from the write
// FIFO, BURST_STOP, PRECHARGE (all banks), then a one-cycle completion pulse.
// Command/address/DQ outputs are registered from the state of the previous
// cycle; wr_ack is decoded from the current state so that the FIFO word read
// on an ack cycle lands on wr_dq together with its WRITE/NOP command.
module sdram_write #(
  parameter int TRCD_CLK = 2,
  parameter int TWR_CLK  = 2,
  parameter int TRP_CLK  = 2
) (
  input  logic         clk,
  input  logic         rstn,
  sdram_write_if.slave bus
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BSTOP = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  // Wait counters count down to zero, so load with (cycles - 1).
  localparam logic [9:0] TRCD_LD = 10'(TRCD_CLK - 1);
  localparam logic [9:0] TWR_LD  = 10'(TWR_CLK - 1);
  localparam logic [9:0] TRP_LD  = 10'(TRP_CLK - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_TRCD, S_WR, S_BSTOP, S_TWR, S_PRE, S_TRP, S_END
  } state_t;

  state_t      r_state;
  logic [23:0] r_addr;
  logic [9:0]  r_len;
  logic [9:0]  r_cnt;
  logic [9:0]  r_ack_cnt;
  logic [3:0]  r_cmd;
  logic [1:0]  r_ba;
  logic [12:0] r_sdram_addr;
  logic [15:0] r_dq;
  logic        r_dq_oe;
  logic        r_end;
  logic        w_ack;

  // FIFO read strobe: one early ack in the last tRCD cycle, then one per WR
  // cycle until the latched length has been requested.
  assign w_ack = ((r_state == S_TRCD) && (r_cnt == 10'd0)) ||
                 ((r_state == S_WR) && (r_ack_cnt < r_len));

  assign bus.wr_ack        = w_ack;
  assign bus.wr_end        = r_end;
  assign bus.wr_cmd        = r_cmd;
  assign bus.wr_ba         = r_ba;
  assign bus.wr_sdram_addr = r_sdram_addr;
  assign bus.wr_dq         = r_dq;
  assign bus.wr_dq_oe      = r_dq_oe;

  // Sequencer and registered SDRAM-side outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_ack_cnt    <= '0;
      r_cmd        <= CMD_NOP;
      r_ba         <= '0;
      r_sdram_addr <= '0;
      r_dq         <= '0;
      r_dq_oe      <= 1'b0;
      r_end        <= 1'b0;
    end else begin
      r_cmd   <= CMD_NOP;
      r_dq_oe <= 1'b0;
      r_end   <= 1'b0;
      if (w_ack) begin
        r_ack_cnt <= r_ack_cnt + 10'd1;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.init_end && bus.wr_en) begin
            r_addr    <= bus.wr_addr;
            r_len     <= bus.wr_burst_len;
            r_ack_cnt <= '0;
            r_cnt     <= '0;
            // A zero-length request only produces the completion pulse.
            r_state   <= (bus.wr_burst_len == 10'd0) ? S_END : S_ACT;
          end
        end
        S_ACT: begin
          r_cmd        <= CMD_ACT;
          r_ba         <= r_addr[23:22];
          r_sdram_addr <= r_addr[21:9];
          r_cnt        <= TRCD_LD;
          r_state      <= S_TRCD;
        end
        S_TRCD: begin
          if (r_cnt == 10'd0) begin
            r_state <= S_WR;
          end else begin
            r_cnt <= r_cnt - 10'd1;
          end
        end
        S_WR: begin
          // Only the first beat carries the WRITE; the page burst continues
          // on NOPs. A10 = 0 keeps auto-precharge off.
          if (r_cnt == 10'd0) begin
            r_cmd        <= CMD_WRITE;
            r_sdram_addr <= {4'b0000, r_addr[8:0]};
          end
          r_dq    <= bus.wr_data;
          r_dq_oe <= 1'b1;
          if (r_cnt == r_len - 10'd1) begin
            r_cnt   <= '0;
            r_state <= S_BSTOP;
          end else begin
            r_cnt <= r_cnt + 10'd1;
          end
        end
        S_BSTOP: begin
          r_cmd   <= CMD_BSTOP;
          r_cnt   <= TWR_LD;
          r_state <= S_TWR;
        end
        S_TWR: begin
          if (r_cnt == 10'd0) begin
            r_state <= S_PRE;
          end else begin
            r_cnt <= r_cnt - 10'd1;
          end
        end
        S_PRE: begin
          r_cmd        <= CMD_PRE;
          r_sdram_addr <= 13'h0400;
          r_cnt        <= TRP_LD;
          r_state      <= S_TRP;
        end
        S_TRP: begin
          if (r_cnt == 10'd0) begin
            r_state <= S_END;
          end else begin
            r_cnt <= r_cnt - 10'd1;
          end
        end
        S_END: begin
          r_end   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_write.sv
// Directed bench for sdram_write: per-cycle log of the SDRAM-side outputs,
// compared against hand-derived cycle positions. Log index i is sampled on
// the falling edge of the i-th cycle after the accept cycle.
`timescale 1ns/1ps
module tb_sdram_write;

  localparam logic [3:0] NOP   = 4'b0111;
  localparam logic [3:0] ACT   = 4'b0011;
  localparam logic [3:0] WRITE = 4'b0100;
  localparam logic [3:0] BSTOP = 4'b0110;
  localparam logic [3:0] PRE   = 4'b0010;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  sdram_write_if bus();

  sdram_write #(.TRCD_CLK(2), .TWR_CLK(2), .TRP_CLK(2)) dut (
    .clk(clk), .rstn(rstn), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] fifo_mem [0:511];
  int          fifo_rd = 0;
  logic        ack_seen = 1'b0;

  logic [3:0]  l_cmd  [0:1199];
  logic [1:0]  l_ba   [0:1199];
  logic [12:0] l_addr [0:1199];
  logic [15:0] l_dq   [0:1199];
  logic        l_oe   [0:1199];
  logic        l_ack  [0:1199];
  logic        l_end  [0:1199];
  int          n = 0;

  // Write-FIFO model: q shows the next word one cycle after each read strobe.
  always @(negedge clk) ack_seen = bus.wr_ack;
  always @(posedge clk) begin
    #1;
    if (ack_seen) begin
      bus.wr_data = fifo_mem[fifo_rd & 511];
      fifo_rd = fifo_rd + 1;
    end
  end

  // Expected per-cycle behaviour (tRCD = tWR = tRP = 2).
  function automatic logic [3:0] exp_cmd(input int i, input int len);
    if (len == 0)            return NOP;
    if (i == 1)              return ACT;
    if (i == 4)              return WRITE;
    if (i == 4 + len)        return BSTOP;
    if (i == 7 + len)        return PRE;
    return NOP;
  endfunction
  function automatic logic exp_ack(input int i, input int len);
    return (len != 0) && (i >= 2) && (i <= 1 + len);
  endfunction
  function automatic logic exp_oe(input int i, input int len);
    return (len != 0) && (i >= 4) && (i <= 3 + len);
  endfunction
  function automatic logic exp_end(input int i, input int len);
    return (len == 0) ? (i == 1) : (i == 10 + len);
  endfunction

  // Issue one request at the current falling edge and log until wr_end.
  // Address/length are scrambled after accept to show they are latched;
  // with misuse set, wr_en and init_end drop mid-operation.
  task automatic run_op(input logic [23:0] addr, input logic [9:0] len,
                        input bit misuse);
    bit got_end = 0;
    bus.init_end     = 1'b1;
    bus.wr_en        = 1'b1;
    bus.wr_addr      = addr;
    bus.wr_burst_len = len;
    n = 0;
    while (n < 1150 && !got_end) begin
      @(negedge clk);
      l_cmd[n]  = bus.wr_cmd;
      l_ba[n]   = bus.wr_ba;
      l_addr[n] = bus.wr_sdram_addr;
      l_dq[n]   = bus.wr_dq;
      l_oe[n]   = bus.wr_dq_oe;
      l_ack[n]  = bus.wr_ack;
      l_end[n]  = bus.wr_end;
      n++;
      if (n == 1) begin
        bus.wr_addr      = 24'hFFFFFF;
        bus.wr_burst_len = 10'h3FF;
      end
      if (misuse && n == 4) begin
        bus.wr_en    = 1'b0;
        bus.init_end = 1'b0;
      end
      if (l_end[n-1]) begin
        got_end = 1;
        bus.wr_en = 1'b0;
      end
    end
    bus.init_end = 1'b1;
    checks++;
    if (!got_end) begin
      errors++;
      $display("FAIL op_timeout: got no wr_end after %0d cycles, required wr_end", n);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.init_end = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_addr = '0;
    bus.wr_burst_len = '0;
    bus.wr_data = '0;
    repeat (3) @(negedge clk);
    checks++; if (bus.wr_cmd !== NOP) begin errors++; $display("FAIL reset_cmd: got %b required %b", bus.wr_cmd, NOP); end
    checks++; if (bus.wr_ba !== 2'd0) begin errors++; $display("FAIL reset_ba: got %h required 0", bus.wr_ba); end
    checks++; if (bus.wr_sdram_addr !== 13'd0) begin errors++; $display("FAIL reset_addr: got %h required 0", bus.wr_sdram_addr); end
    checks++; if (bus.wr_dq !== 16'd0) begin errors++; $display("FAIL reset_dq: got %h required 0", bus.wr_dq); end
    checks++; if (bus.wr_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b required 0", bus.wr_dq_oe); end
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", bus.wr_ack); end
    checks++; if (bus.wr_end !== 1'b0) begin errors++; $display("FAIL reset_end: got %b required 0", bus.wr_end); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill_basic();
    fifo_mem[0] = 16'h1111; fifo_mem[1] = 16'h2222;
    fifo_mem[2] = 16'h3333; fifo_mem[3] = 16'h4444;
    fifo_rd = 0;
  endtask

  task automatic test_basic_burst();
    int acks = 0;
    fill_basic();
    run_op(24'h400A05, 10'd4, 1'b0);
    checks++; if (n !== 15) begin errors++; $display("FAIL basic_len: got %0d cycles required 15", n); end
    for (int i = 0; i < n && i < 15; i++) begin
      checks++; if (l_cmd[i] !== exp_cmd(i, 4)) begin errors++; $display("FAIL basic_cmd[%0d]: got %b required %b", i, l_cmd[i], exp_cmd(i, 4)); end
      checks++; if (l_ack[i] !== exp_ack(i, 4)) begin errors++; $display("FAIL basic_ack[%0d]: got %b required %b", i, l_ack[i], exp_ack(i, 4)); end
      checks++; if (l_oe[i] !== exp_oe(i, 4)) begin errors++; $display("FAIL basic_oe[%0d]: got %b required %b", i, l_oe[i], exp_oe(i, 4)); end
      checks++; if (l_end[i] !== exp_end(i, 4)) begin errors++; $display("FAIL basic_end[%0d]: got %b required %b", i, l_end[i], exp_end(i, 4)); end
      if (l_ack[i] === 1'b1) acks++;
    end
    checks++; if (acks !== 4) begin errors++; $display("FAIL basic_ack_count: got %0d required 4", acks); end
    checks++; if (l_ba[1] !== 2'd1) begin errors++; $display("FAIL basic_act_ba: got %h required 1", l_ba[1]); end
    checks++; if (l_addr[1] !== 13'h0005) begin errors++; $display("FAIL basic_act_row: got %h required 0005", l_addr[1]); end
    checks++; if (l_ba[4] !== 2'd1) begin errors++; $display("FAIL basic_wr_ba: got %h required 1", l_ba[4]); end
    checks++; if (l_addr[4] !== 13'h0005) begin errors++; $display("FAIL basic_wr_col: got %h required 0005", l_addr[4]); end
    for (int k = 0; k < 4; k++) begin
      checks++; if (l_dq[4+k] !== fifo_mem[k]) begin errors++; $display("FAIL basic_dq[%0d]: got %h required %h", k, l_dq[4+k], fifo_mem[k]); end
    end
    checks++; if (l_addr[11][10] !== 1'b1) begin errors++; $display("FAIL basic_pre_a10: got %b required 1", l_addr[11][10]); end
  endtask

  task automatic test_len_zero();
    int bad = 0;
    fifo_rd = 0;
    run_op(24'h123456, 10'd0, 1'b0);
    checks++; if (n !== 2) begin errors++; $display("FAIL zero_end_pos: got %0d cycles required 2", n); end
    for (int i = 0; i < n; i++) if (l_cmd[i] !== NOP || l_ack[i] !== 1'b0) bad++;
    checks++; if (bad !== 0) begin errors++; $display("FAIL zero_activity: got %0d active cycles required 0", bad); end
  endtask

  task automatic test_full_page();
    int acks = 0, oes = 0, wrs = 0, bss = 0, bad = 0, first_ack = -1, last_ack = -1;
    for (int k = 0; k < 512; k++) fifo_mem[k] = 16'(k * 3 + 16'h0100);
    fifo_rd = 0;
    run_op({2'd2, 13'h0123, 9'h000}, 10'd512, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (l_ack[i] === 1'b1) begin acks++; if (first_ack < 0) first_ack = i; last_ack = i; end
      if (l_oe[i] === 1'b1) begin
        oes++;
        if (i < 4 || l_dq[i] !== fifo_mem[(i - 4) & 511]) bad++;
      end
      if (l_cmd[i] === WRITE) wrs++;
      if (l_cmd[i] === BSTOP) bss++;
    end
    checks++; if (acks !== 512) begin errors++; $display("FAIL full_acks: got %0d required 512", acks); end
    checks++; if (oes !== 512) begin errors++; $display("FAIL full_oe: got %0d required 512", oes); end
    checks++; if (wrs !== 1) begin errors++; $display("FAIL full_writes: got %0d required 1", wrs); end
    checks++; if (bss !== 1) begin errors++; $display("FAIL full_bstops: got %0d required 1", bss); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL full_data: got %0d bad words required 0", bad); end
    checks++; if (first_ack !== 2 || last_ack !== 513) begin errors++; $display("FAIL full_ack_window: got %0d..%0d required 2..513", first_ack, last_ack); end
    checks++; if (l_cmd[516] !== BSTOP) begin errors++; $display("FAIL full_bstop_pos: got %b required %b", l_cmd[516], BSTOP); end
    checks++; if (n !== 523) begin errors++; $display("FAIL full_end_pos: got %0d cycles required 523", n); end
  endtask

  task automatic test_column_wrap();
    int acts = 0, wrs = 0, oes = 0;
    for (int k = 0; k < 4; k++) fifo_mem[k] = 16'hA000 + 16'(k);
    fifo_rd = 0;
    run_op(24'h0021FE, 10'd4, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (l_cmd[i] === ACT) acts++;
      if (l_cmd[i] === WRITE) wrs++;
      if (l_oe[i] === 1'b1) oes++;
    end
    checks++; if (acts !== 1) begin errors++; $display("FAIL wrap_acts: got %0d required 1", acts); end
    checks++; if (wrs !== 1) begin errors++; $display("FAIL wrap_writes: got %0d required 1", wrs); end
    checks++; if (oes !== 4) begin errors++; $display("FAIL wrap_oe: got %0d required 4", oes); end
    checks++; if (l_addr[4] !== 13'h01FE) begin errors++; $display("FAIL wrap_col: got %h required 01fe", l_addr[4]); end
    checks++; if (l_addr[1] !== 13'h0010) begin errors++; $display("FAIL wrap_row: got %h required 0010", l_addr[1]); end
    checks++; if (l_dq[7] !== 16'hA003) begin errors++; $display("FAIL wrap_last_dq: got %h required a003", l_dq[7]); end
  endtask

  task automatic test_reset_mid_burst();
    int ends = 0, cmds = 0;
    for (int k = 0; k < 8; k++) fifo_mem[k] = 16'h5000 + 16'(k);
    fifo_rd = 0;
    bus.init_end = 1'b1; bus.wr_en = 1'b1;
    bus.wr_addr = 24'h400A05; bus.wr_burst_len = 10'd8;
    repeat (7) @(negedge clk);
    checks++; if (bus.wr_dq_oe !== 1'b1 || bus.wr_dq !== 16'h5002) begin errors++; $display("FAIL rst_pre_state: got oe %b dq %h required oe 1 dq 5002", bus.wr_dq_oe, bus.wr_dq); end
    rstn = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    checks++; if (bus.wr_cmd !== NOP) begin errors++; $display("FAIL rst_mid_cmd: got %b required %b", bus.wr_cmd, NOP); end
    checks++; if (bus.wr_dq_oe !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b required 0", bus.wr_dq_oe); end
    checks++; if (bus.wr_ack !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b required 0", bus.wr_ack); end
    checks++; if (bus.wr_dq !== 16'd0) begin errors++; $display("FAIL rst_mid_dq: got %h required 0", bus.wr_dq); end
    rstn = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.wr_end !== 1'b0) ends++;
      if (bus.wr_cmd !== NOP) cmds++;
    end
    checks++; if (ends !== 0) begin errors++; $display("FAIL rst_no_end: got %0d pulses required 0", ends); end
    checks++; if (cmds !== 0) begin errors++; $display("FAIL rst_idle_cmds: got %0d commands required 0", cmds); end
    fill_basic();
    run_op(24'h400A05, 10'd4, 1'b0);
    checks++; if (n !== 15) begin errors++; $display("FAIL rst_retry_len: got %0d cycles required 15", n); end
    checks++; if (l_cmd[1] !== ACT || l_ba[1] !== 2'd1 || l_addr[1] !== 13'h0005) begin errors++; $display("FAIL rst_retry_act: got %b/%h/%h required 0011/1/0005", l_cmd[1], l_ba[1], l_addr[1]); end
    checks++; if (l_cmd[4] !== WRITE || l_dq[4] !== 16'h1111) begin errors++; $display("FAIL rst_retry_write: got %b/%h required 0100/1111", l_cmd[4], l_dq[4]); end
    checks++; if (l_dq[7] !== 16'h4444) begin errors++; $display("FAIL rst_retry_dq3: got %h required 4444", l_dq[7]); end
  endtask

  task automatic test_gating();
    int busy = 0;
    fill_basic();
    bus.init_end = 1'b0; bus.wr_en = 1'b1;
    bus.wr_addr = 24'h400A05; bus.wr_burst_len = 10'd4;
    repeat (6) begin
      @(negedge clk);
      if (bus.wr_cmd !== NOP || bus.wr_ack !== 1'b0 || bus.wr_end !== 1'b0) busy++;
    end
    checks++; if (busy !== 0) begin errors++; $display("FAIL gate_idle: got %0d busy cycles required 0", busy); end
    run_op(24'h400A05, 10'd4, 1'b0);
    checks++; if (l_cmd[0] !== NOP) begin errors++; $display("FAIL gate_first: got %b required %b", l_cmd[0], NOP); end
    checks++; if (l_cmd[1] !== ACT) begin errors++; $display("FAIL gate_act: got %b required %b", l_cmd[1], ACT); end
    checks++; if (n !== 15) begin errors++; $display("FAIL gate_len: got %0d cycles required 15", n); end
  endtask

  task automatic test_misuse();
    fifo_mem[0] = 16'hBEEF; fifo_mem[1] = 16'hCAFE;
    fifo_rd = 0;
    run_op(24'hC00200, 10'd2, 1'b1);
    checks++; if (n !== 13) begin errors++; $display("FAIL misuse_len: got %0d cycles required 13", n); end
    checks++; if (l_cmd[6] !== BSTOP) begin errors++; $display("FAIL misuse_bstop: got %b required %b", l_cmd[6], BSTOP); end
    checks++; if (l_cmd[9] !== PRE) begin errors++; $display("FAIL misuse_pre: got %b required %b", l_cmd[9], PRE); end
    checks++; if (l_dq[5] !== 16'hCAFE) begin errors++; $display("FAIL misuse_dq: got %h required cafe", l_dq[5]); end
    checks++; if (l_ba[1] !== 2'd3 || l_addr[1] !== 13'h0001) begin errors++; $display("FAIL misuse_act: got %h/%h required 3/0001", l_ba[1], l_addr[1]); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) fifo_mem[k] = 16'h7700 + 16'(k);
    fifo_rd = 0;
    run_op(24'h000C03, 10'd3, 1'b0);
    checks++; if (n !== 14) begin errors++; $display("FAIL b2b_first_len: got %0d cycles required 14", n); end
    fifo_mem[0] = 16'h8800; fifo_mem[1] = 16'h8801;
    fifo_rd = 0;
    run_op(24'h800E10, 10'd2, 1'b0);
    checks++; if (l_cmd[1] !== ACT || l_ba[1] !== 2'd2 || l_addr[1] !== 13'h0007) begin errors++; $display("FAIL b2b_act: got %b/%h/%h required 0011/2/0007", l_cmd[1], l_ba[1], l_addr[1]); end
    checks++; if (l_addr[4] !== 13'h0010 || l_dq[4] !== 16'h8800) begin errors++; $display("FAIL b2b_write: got %h/%h required 0010/8800", l_addr[4], l_dq[4]); end
    checks++; if (n !== 13) begin errors++; $display("FAIL b2b_second_len: got %0d cycles required 13", n); end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_len_zero();
    test_full_page();
    test_column_wrap();
    test_reset_mid_burst();
    test_gating();
    test_misuse();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_write.md
Name: sdram_write

Overview:
- SDRAM-side responder to the FIFO controller's write request.
- Once the arbiter grants a write (wr_en), it opens the target row, streams one full-page-mode burst of wr_burst_len words out of the write FIFO, terminates the burst, precharges, and signals completion.
- Drives the write-phase command/address/DQ bus that the arbiter muxes onto the W9825G6KH pins.
- Generates wr_ack, which the FIFO controller uses both as its FIFO read strobe and for next-address advance on the falling edge.

Parameters:
- TRCD_CLK, 2, NOPs between ACTIVE and WRITE (tRCD in clk cycles).
- TWR_CLK, 2, NOPs between BURST_STOP and PRECHARGE (tWR).
- TRP_CLK, 2, NOPs after PRECHARGE before wr_end (tRP).

Ports:
- clk  in  1  system clock (100 MHz SDRAM domain).
- rstn  in  1  reset; synchronous, active-low.
- init_end  in  1  SDRAM power-up init complete; wr_en is ignored while low.
- wr_en  in  1  arbiter grant; level, held until wr_end.
- wr_addr  in  24  start address: bank = [23:22], row = [21:9], column = [8:0].
- wr_burst_len  in  10  words in this burst, 0..512.
- wr_data  in  16  write-FIFO q; valid the cycle after each wr_ack cycle.
- wr_ack  out  1  FIFO read strobe; high for exactly wr_burst_len consecutive cycles.
- wr_end  out  1  one-cycle pulse when the operation is finished and the bus is released.
- wr_cmd  out  4  {CS_n, RAS_n, CAS_n, WE_n}.
- wr_ba  out  2  bank address.
- wr_sdram_addr  out  13  row/column/A10 address.
- wr_dq  out  16  write data.
- wr_dq_oe  out  1  DQ output enable.

Behaviour:
- Command encodings: NOP = 0111, ACTIVE = 0011, WRITE = 0100, BURST_STOP = 0110, PRECHARGE = 0010.
- Reset (rstn = 0 at a clk edge), including mid-burst: state → IDLE, counters → 0, wr_cmd = NOP, wr_ba = 0, wr_sdram_addr = 0, wr_dq = 0, wr_dq_oe = 0, wr_ack = 0, wr_end = 0. Nothing is resumed; the FIFO controller restarts the request.
- All SDRAM-side outputs are registered. wr_ack is combinational from the state, so FIFO data and the WRITE/DQ outputs stay aligned.
- On accept (IDLE, init_end & wr_en), latch wr_addr and wr_burst_len. Later changes to these inputs are ignored until the next accept.
- FSM states: IDLE, ACT, TRCD, WR, BSTOP, TWR, PRE, TRP, END.
  - IDLE → ACT on accept. If the latched length is 0 → END instead: no commands, no ack.
  - ACT, one cycle: output ACTIVE, ba = addr[23:22], sdram_addr = addr[21:9].
  - TRCD: NOP for TRCD_CLK cycles. wr_ack rises in the last TRCD cycle.
  - WR, len cycles: wr_ack stays high until len acks have been issued, with no gaps.
    - First WR cycle outputs WRITE, ba, sdram_addr = {4'b0, addr[8:0]} (A10 = 0, no auto-precharge), wr_dq = first word, wr_dq_oe = 1.
    - Remaining cycles output NOP with the next words.
    - Total DQ cycles = len.
  - BSTOP, one cycle: output BURST_STOP, wr_dq_oe = 0.
  - TWR: NOP for TWR_CLK cycles.
  - PRE, one cycle: output PRECHARGE with A10 = 1 (all banks).
  - TRP: NOP for TRP_CLK cycles.
  - END, one cycle: wr_end = 1, → IDLE. wr_en is expected to drop in the cycle after wr_end.
- Ack/data timing: with the first ack on cycle t, wr_data is valid at t+1..t+len and appears on wr_dq at t+2..t+len+1. The first WRITE command output is at t+2.
- Column wrap: if column + len > 512, the SDRAM full-page burst wraps within the row. The block does not split the burst or change row.
- len = 512: every column of the row is written once, then BURST_STOP.
- wr_en dropping mid-operation (arbiter misuse): ignored; the sequence always completes.
- init_end dropping mid-operation: ignored.
- Counters are 10-bit: the wait counter reloads on each state entry; the ack/data counters compare against the latched len.
- Back-to-back: at least one IDLE cycle separates consecutive operations.

Test Plan:
- Basic burst: wr_addr = 0x40_0A05, len = 4, data 0x1111..0x4444.
  - wr_ack is high for exactly 4 cycles.
  - Command sequence: ACTIVE (ba = 1, row = 0x005), 2×NOP, WRITE (col = 0x005) with 0x1111, then 0x2222/0x3333/0x4444, BURST_STOP, 2×NOP, PRECHARGE with A10 = 1, 2×NOP, wr_end pulse.
- Length 0: wr_en with len = 0 → no wr_ack, wr_cmd stays NOP, wr_end pulses 2 cycles after accept.
- Full page: col = 0, len = 512 → exactly 512 acks and 512 DQ cycles, wr_dq_oe high 512 cycles, one WRITE, one BURST_STOP.
- Column wrap: col = 0x1FE, len = 4 → a single WRITE at col 0x1FE, 4 data cycles, no second ACTIVE.
- Reset mid-burst: rstn = 0 on the 3rd data cycle of a len = 8 burst → next edge wr_cmd = NOP, wr_dq_oe = 0, wr_ack = 0, no wr_end. A fresh request after release behaves as in the basic burst test.
- Gating: wr_en = 1 with init_end = 0 → no activity. Raising init_end → ACTIVE 2 cycles later (accept edge, then ACT output).
